palette_lut: RTL and testbench

Programmable, pipelined colour-index-to-RGB lookup for the video output path. It generalises the fixed 3-bit → 8-bit (RRRGGGBB) colour decoder with a parametrised index width, a run-time writable palette, per-entry flashing and blanking, and a transparency flag for the compositor. It sits between the sprite/playfield priority mux (colour index source) and the VGA output register.

---
 rtl/palette_lut_if.sv | 31 +++
 rtl/palette_lut.sv | 114 +++++++++++
 tb/tb_palette_lut.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/palette_lut_if.sv
// Pixel stream, palette write port and registered RGB result of the palette lookup.
interface palette_lut_if #(
  parameter int IDX_W = 3
);
  logic             pix_valid_in;
  logic [IDX_W-1:0] color_in;
  logic             blank_in;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  logic             wr_flash;
  logic             flash_en;
  logic             frame_tick;
  logic [7:0]       rgb_out;
  logic             rgb_valid;
  logic             transp_out;

  modport master (
    output pix_valid_in, color_in, blank_in,
    output wr_en, wr_addr, wr_data, wr_flash,
    output flash_en, frame_tick,
    input  rgb_out, rgb_valid, transp_out
  );

  modport slave (
    input  pix_valid_in, color_in, blank_in,
    input  wr_en, wr_addr, wr_data, wr_flash,
    input  flash_en, frame_tick,
    output rgb_out, rgb_valid, transp_out
  );
endinterface

// File: rtl/palette_lut.sv
// Two-stage colour-index to RRRGGGBB lookup with a writable palette,
// per-entry flashing driven by frame ticks, blanking and a transparency flag.
module palette_lut #(
  parameter int IDX_W      = 3,
  parameter int FLASH_DIV  = 16,
  parameter int TRANSP_IDX = 7
) (
  input logic         clk,
  input logic         rst_n,
  palette_lut_if.slave bus
);
  localparam int ENTRIES = 2 ** IDX_W;
  localparam int DIV_LAST_I = FLASH_DIV - 1;
  localparam logic [7:0] DIV_LAST = DIV_LAST_I[7:0];
  localparam logic [IDX_W-1:0] TRANSP = TRANSP_IDX[IDX_W-1:0];

  typedef enum logic {
    PHASE_OFF = 1'b0,
    PHASE_ON  = 1'b1
  } phase_t;

  // Entries 0..7 mirror the legacy fixed 3-bit colour decoder.
  function automatic logic [7:0] default_entry(input int i);
    case (i)
      1:       return 8'hE0;
      2:       return 8'h1C;
      3:       return 8'hFC;
      4:       return 8'h1F;
      5:       return 8'hE3;
      6:       return 8'hE0;
      default: return 8'h00;
    endcase
  endfunction

  logic [7:0]       palette [ENTRIES];
  logic [ENTRIES-1:0] flash_mask;

  logic             s1_valid;
  logic [IDX_W-1:0] s1_idx;
  logic             s1_blank;

  phase_t           phase_q, phase_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       rgb_d;
  logic             flash_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) palette[i] <= default_entry(i);
      flash_mask <= '0;
    end else if (bus.wr_en) begin
      palette[bus.wr_addr]    <= bus.wr_data;
      flash_mask[bus.wr_addr] <= bus.wr_flash;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_blank <= 1'b0;
    end else begin
      s1_valid <= bus.pix_valid_in;
      s1_idx   <= bus.color_in;
      s1_blank <= bus.blank_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= PHASE_OFF;
      cnt_q   <= 8'd0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // Dropping flash_en parks the phase so flashing entries show immediately.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (!bus.flash_en) begin
      phase_d = PHASE_OFF;
      cnt_d   = 8'd0;
    end else if (bus.frame_tick) begin
      if (cnt_q == DIV_LAST) begin
        cnt_d   = 8'd0;
        phase_d = (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  // Palette is read before any same-edge write lands.
  always_comb begin
    flash_hit = (phase_q == PHASE_ON) && flash_mask[s1_idx];
    rgb_d     = palette[s1_idx];
    if (!s1_valid || s1_blank || flash_hit) rgb_d = 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rgb_out    <= 8'h00;
      bus.rgb_valid  <= 1'b0;
      bus.transp_out <= 1'b0;
    end else begin
      bus.rgb_out    <= rgb_d;
      bus.rgb_valid  <= s1_valid;
      bus.transp_out <= s1_valid && !s1_blank && (s1_idx == TRANSP);
    end
  end
endmodule

// File: tb/tb_palette_lut.sv
// Directed bench for palette_lut: a 3-bit-index instance and a 4-bit-index instance, both FLASH_DIV=2.
module tb_palette_lut;
  logic clk;
  logic rst_n;
  int   assert_count;
  int   fail_count;

  palette_lut_if #(.IDX_W(3)) bus3 ();
  palette_lut_if #(.IDX_W(4)) bus4 ();

  palette_lut #(.IDX_W(3), .FLASH_DIV(2), .TRANSP_IDX(7)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus3.slave)
  );

  palette_lut #(.IDX_W(4), .FLASH_DIV(2), .TRANSP_IDX(7)) dut4 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] exp_default [8] = '{8'h00, 8'hE0, 8'h1C, 8'hFC, 8'h1F, 8'hE3, 8'hE0, 8'h00};

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Observed word is {rgb_valid, transp_out, rgb_out}.
  function automatic logic [31:0] outWord(input bit sel);
    if (sel) return {22'd0, bus4.rgb_valid, bus4.transp_out, bus4.rgb_out};
    else     return {22'd0, bus3.rgb_valid, bus3.transp_out, bus3.rgb_out};
  endfunction

  function automatic logic [31:0] expWord(input bit valid, input bit transp, input logic [7:0] rgb);
    return {22'd0, valid, transp, rgb};
  endfunction

  task automatic applyStimulus(input bit sel, input bit valid, input logic [3:0] idx, input bit blank);
    @(negedge clk);
    if (sel) begin
      bus4.pix_valid_in = valid;
      bus4.color_in     = idx;
      bus4.blank_in     = blank;
    end else begin
      bus3.pix_valid_in = valid;
      bus3.color_in     = idx[2:0];
      bus3.blank_in     = blank;
    end
  endtask

  task automatic writeEntry(input bit sel, input logic [3:0] addr, input logic [7:0] data, input bit flash);
    @(negedge clk);
    if (sel) begin
      bus4.wr_en = 1'b1; bus4.wr_addr = addr; bus4.wr_data = data; bus4.wr_flash = flash;
    end else begin
      bus3.wr_en = 1'b1; bus3.wr_addr = addr[2:0]; bus3.wr_data = data; bus3.wr_flash = flash;
    end
    @(negedge clk);
    bus3.wr_en = 1'b0;
    bus4.wr_en = 1'b0;
  endtask

  task automatic sendAndCheck(input bit sel, input string tag, input logic [3:0] idx, input bit blank,
                              input bit exp_transp, input logic [7:0] exp_rgb);
    applyStimulus(sel, 1'b1, idx, blank);
    applyStimulus(sel, 1'b0, 4'd0, 1'b0);
    @(negedge clk);
    checkOutput(tag, outWord(sel), expWord(1'b1, exp_transp, exp_rgb));
  endtask

  task automatic frameTick();
    @(negedge clk);
    bus3.frame_tick = 1'b1;
    @(negedge clk);
    bus3.frame_tick = 1'b0;
  endtask

  initial begin
    assert_count = 0;
    fail_count   = 0;
    rst_n        = 1'b0;
    bus3.pix_valid_in = 0; bus3.color_in = '0; bus3.blank_in = 0;
    bus3.wr_en = 0; bus3.wr_addr = '0; bus3.wr_data = '0; bus3.wr_flash = 0;
    bus3.flash_en = 0; bus3.frame_tick = 0;
    bus4.pix_valid_in = 0; bus4.color_in = '0; bus4.blank_in = 0;
    bus4.wr_en = 0; bus4.wr_addr = '0; bus4.wr_data = '0; bus4.wr_flash = 0;
    bus4.flash_en = 0; bus4.frame_tick = 0;

    #1;
    checkOutput("reset_state", outWord(1'b0), expWord(1'b0, 1'b0, 8'h00));
    checkOutput("reset_state4", outWord(1'b1), expWord(1'b0, 1'b0, 8'h00));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back default palette stream, output two edges after each sample.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 2)
        checkOutput($sformatf("default_idx%0d", k - 2), outWord(1'b0),
                    expWord(1'b1, (k - 2) == 7, exp_default[k - 2]));
      bus3.pix_valid_in = (k < 8);
      bus3.color_in     = 3'(k);
    end
    bus3.pix_valid_in = 1'b0;

    // Write lands on the edge that moves the index-3 pixel into stage 2.
    applyStimulus(1'b0, 1'b1, 4'd3, 1'b0);
    @(negedge clk);
    bus3.pix_valid_in = 1'b0;
    bus3.wr_en = 1'b1; bus3.wr_addr = 3'd3; bus3.wr_data = 8'h55; bus3.wr_flash = 1'b0;
    @(negedge clk);
    bus3.wr_en = 1'b0;
    checkOutput("hazard_old", outWord(1'b0), expWord(1'b1, 1'b0, 8'hFC));
    sendAndCheck(1'b0, "hazard_new", 4'd3, 1'b0, 1'b0, 8'h55);

    // Blank and invalid pixels, pipelined.
    sendAndCheck(1'b0, "blank_idx1", 4'd1, 1'b1, 1'b0, 8'h00);
    sendAndCheck(1'b0, "blank_idx7", 4'd7, 1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 4'd5, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'd5, 1'b0);
    @(negedge clk);
    checkOutput("valid_idx5", outWord(1'b0), expWord(1'b1, 1'b0, 8'hE3));
    @(negedge clk);
    checkOutput("invalid", outWord(1'b0), expWord(1'b0, 1'b0, 8'h00));

    // Flashing entry 2 with FLASH_DIV=2.
    writeEntry(1'b0, 4'd2, 8'h1C, 1'b1);
    bus3.flash_en = 1'b1;
    frameTick();
    sendAndCheck(1'b0, "flash_tick1", 4'd2, 1'b0, 1'b0, 8'h1C);
    frameTick();
    sendAndCheck(1'b0, "flash_on_idx2", 4'd2, 1'b0, 1'b0, 8'h00);
    sendAndCheck(1'b0, "flash_on_idx4", 4'd4, 1'b0, 1'b0, 8'h1F);
    frameTick();
    sendAndCheck(1'b0, "flash_tick3", 4'd2, 1'b0, 1'b0, 8'h00);
    frameTick();
    sendAndCheck(1'b0, "flash_off_idx2", 4'd2, 1'b0, 1'b0, 8'h1C);
    frameTick();
    frameTick();
    sendAndCheck(1'b0, "flash_on_again", 4'd2, 1'b0, 1'b0, 8'h00);
    bus3.flash_en = 1'b0;
    sendAndCheck(1'b0, "flash_disabled", 4'd2, 1'b0, 1'b0, 8'h1C);

    // Asynchronous reset in the middle of a pixel stream.
    writeEntry(1'b0, 4'd1, 8'hAA, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("pre_reset", outWord(1'b0), expWord(1'b1, 1'b0, 8'hAA));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset", outWord(1'b0), expWord(1'b0, 1'b0, 8'h00));
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0);
    rst_n = 1'b1;
    sendAndCheck(1'b0, "post_reset_idx1", 4'd1, 1'b0, 1'b0, 8'hE0);
    sendAndCheck(1'b0, "post_reset_idx3", 4'd3, 1'b0, 1'b0, 8'hFC);

    // Wider index: upper entries default to black and are writable.
    sendAndCheck(1'b1, "w4_idx12_default", 4'd12, 1'b0, 1'b0, 8'h00);
    writeEntry(1'b1, 4'd12, 8'h3C, 1'b0);
    sendAndCheck(1'b1, "w4_idx12_written", 4'd12, 1'b0, 1'b0, 8'h3C);
    sendAndCheck(1'b1, "w4_idx5", 4'd5, 1'b0, 1'b0, 8'hE3);
    sendAndCheck(1'b1, "w4_idx7", 4'd7, 1'b0, 1'b1, 8'h00);
    sendAndCheck(1'b1, "w4_idx2", 4'd2, 1'b0, 1'b0, 8'h1C);
    sendAndCheck(1'b1, "w4_idx15", 4'd15, 1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
